// File: rtl/exception_arbiter_if.sv
// rtl/exception_arbiter_if.sv - commit and fetch-redirect handshake bundle for exception_arbiter
interface exception_arbiter_if;
  logic        commit_valid;
  logic        commit_ready;
  logic [31:0] commit_pc;
  logic        commit_isds;
  logic [3:0]  commit_exc;
  logic [31:0] commit_badva;
  logic        commit_retire;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  modport slave (
    input  commit_valid, commit_pc, commit_isds, commit_exc, commit_badva, redirect_ready,
    output commit_ready, commit_retire, redirect_valid, redirect_pc
  );

  modport master (
    output commit_valid, commit_pc, commit_isds, commit_exc, commit_badva, redirect_ready,
    input  commit_ready, commit_retire, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/exception_arbiter.sv
// rtl/exception_arbiter.sv - picks exceptions/ERET/interrupts at commit, drives CP0 update, flush and redirect
// Optional feature macro: EXC_INT_SYNC_EN (2-flop hw_int synchronizer; default is one register stage).
module exception_arbiter #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380
) (
  input  logic                      clk,
  input  logic                      rst,
  exception_arbiter_if.slave        bus,
  input  logic [5:0]                hw_int,
  input  logic                      status_ie,
  input  logic                      status_exl,
  input  logic [5:0]                status_im,
  input  logic [1:0]                status_im_sw,
  input  logic [1:0]                cause_ip_sw,
  input  logic                      counter_int,
  input  logic [31:0]               cp0_epc,
  output logic [5:0]                int_to_cp0,
  output logic                      cause_exce,
  output logic [3:0]                exce_type,
  output logic [31:0]               exce_pc,
  output logic                      exce_isds,
  output logic [31:0]               exce_badva,
  output logic                      flush
);

  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

  state_t      state, state_nxt;
  logic [5:0]  int_sync;
  logic [3:0]  flush_cnt;
  logic [31:0] target;
  logic        idle_ready;
  logic        accept;
  logic        int_req;
  logic        ev_valid;
  logic [3:0]  ev_type;

`ifdef EXC_INT_SYNC_EN
  logic [5:0] int_meta;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_meta <= '0;
      int_sync <= '0;
    end else begin
      int_meta <= hw_int;
      int_sync <= int_meta;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) int_sync <= '0;
    else     int_sync <= hw_int;
  end
`endif

  // Timer match shares IP7 with the top external line.
  assign int_to_cp0 = {int_sync[5] | (counter_int & ~rst), int_sync[4:0]};

  assign int_req    = status_ie & ~status_exl &
                      ((|(int_to_cp0 & status_im)) | (|(cause_ip_sw & status_im_sw)));
  assign idle_ready = (state == IDLE) & ~rst;
  assign accept     = bus.commit_valid & idle_ready;
  assign ev_valid   = accept & (int_req | (bus.commit_exc != 4'd0));
  assign ev_type    = int_req ? 4'd1 : bus.commit_exc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (ev_valid) state_nxt = FLUSH;
      FLUSH:    if (flush_cnt == 4'd1) state_nxt = REDIRECT;
      REDIRECT: if (bus.redirect_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Payload is only rewritten by a new event so CP0 may read it at leisure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cause_exce <= 1'b0;
      exce_type  <= '0;
      exce_pc    <= '0;
      exce_isds  <= 1'b0;
      exce_badva <= '0;
      target     <= '0;
      flush_cnt  <= '0;
    end else begin
      cause_exce <= ev_valid;
      if (ev_valid) begin
        exce_type  <= ev_type;
        exce_pc    <= bus.commit_pc;
        exce_isds  <= bus.commit_isds;
        exce_badva <= (ev_type == 4'd2 || ev_type == 4'd7) ? bus.commit_badva : 32'd0;
        target     <= (ev_type == 4'd8) ? cp0_epc : EXC_VECTOR;
        flush_cnt  <= 4'(FLUSH_CYCLES);
      end else if (state == FLUSH) begin
        flush_cnt  <= flush_cnt - 4'd1;
      end
    end
  end

  always_comb begin
    bus.commit_ready   = idle_ready;
    bus.commit_retire  = accept & ~ev_valid;
    flush              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    case (state)
      FLUSH:    flush = 1'b1;
      REDIRECT: begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
      end
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_exception_arbiter.sv
// tb/tb_exception_arbiter.sv - directed plus randomized checks of exception_arbiter against a reference model
module tb_exception_arbiter;

  localparam int unsigned FC = 2;
  localparam logic [31:0] EV = 32'hBFC00380;
`ifdef EXC_INT_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  hw_int;
  logic        status_ie, status_exl, counter_int;
  logic [5:0]  status_im;
  logic [1:0]  status_im_sw, cause_ip_sw;
  logic [31:0] cp0_epc;
  logic [5:0]  int_to_cp0;
  logic        cause_exce, exce_isds, flush;
  logic [3:0]  exce_type;
  logic [31:0] exce_pc, exce_badva;

  exception_arbiter_if bus ();

  exception_arbiter #(.FLUSH_CYCLES(FC), .EXC_VECTOR(EV)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .hw_int(hw_int), .status_ie(status_ie), .status_exl(status_exl),
    .status_im(status_im), .status_im_sw(status_im_sw), .cause_ip_sw(cause_ip_sw),
    .counter_int(counter_int), .cp0_epc(cp0_epc), .int_to_cp0(int_to_cp0),
    .cause_exce(cause_exce), .exce_type(exce_type), .exce_pc(exce_pc),
    .exce_isds(exce_isds), .exce_badva(exce_badva), .flush(flush)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [5:0]  hist[$];
  logic [3:0]  last_type;
  logic [31:0] last_pc, last_badva;
  logic        last_isds;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; hw_int as seen at each rising edge feeds the latency model.
  task automatic tick();
    @(posedge clk);
    if (rst) hist.delete();
    else     hist.push_front(hw_int);
    if (hist.size() > 4) void'(hist.pop_back());
    @(negedge clk);
  endtask

  function automatic logic [5:0] exp_i2c();
    logic [5:0] s;
    s = (hist.size() >= SYNC_LAT) ? hist[SYNC_LAT-1] : 6'd0;
    return s | {counter_int, 5'd0};
  endfunction

  task automatic idle_cycle();
    bus.commit_valid = 1'b0;
    #1;
    chk("idle_i2c", {26'd0, int_to_cp0}, {26'd0, exp_i2c()});
    chk("idle_cause", {31'd0, cause_exce}, 32'd0);
    chk("idle_retire", {31'd0, bus.commit_retire}, 32'd0);
    tick();
  endtask

  task automatic commit(input logic [31:0] pc, input logic isds, input logic [3:0] exc,
                        input logic [31:0] badva, input int stall);
    logic ireq, ev;
    logic [3:0] typ;
    logic [31:0] tgt;
    bus.commit_valid = 1'b1;
    bus.commit_pc    = pc;
    bus.commit_isds  = isds;
    bus.commit_exc   = exc;
    bus.commit_badva = badva;
    #1;
    ireq = status_ie && !status_exl &&
           (((exp_i2c() & status_im) != 6'd0) || ((cause_ip_sw & status_im_sw) != 2'd0));
    ev   = ireq || (exc != 4'd0);
    typ  = ireq ? 4'd1 : exc;
    tgt  = (typ == 4'd8) ? cp0_epc : EV;
    chk("ready_idle", {31'd0, bus.commit_ready}, 32'd1);
    chk("i2c", {26'd0, int_to_cp0}, {26'd0, exp_i2c()});
    chk("retire", {31'd0, bus.commit_retire}, {31'd0, !ev});
    tick();
    bus.commit_valid = 1'b0;
    cp0_epc = $urandom;
    #1;
    chk("cause_pulse", {31'd0, cause_exce}, {31'd0, ev});
    if (ev) begin
      last_type  = typ;
      last_pc    = pc;
      last_isds  = isds;
      last_badva = (typ == 4'd2 || typ == 4'd7) ? badva : 32'd0;
    end
    chk("exce_type", {28'd0, exce_type}, {28'd0, last_type});
    chk("exce_pc", exce_pc, last_pc);
    chk("exce_isds", {31'd0, exce_isds}, {31'd0, last_isds});
    chk("exce_badva", exce_badva, last_badva);
    if (ev) begin
      for (int k = 0; k < int'(FC); k++) begin
        if (k > 0) begin
          tick();
          #1;
          chk("cause_once", {31'd0, cause_exce}, 32'd0);
        end
        chk("flush_hi", {31'd0, flush}, 32'd1);
        chk("busy_ready", {31'd0, bus.commit_ready}, 32'd0);
        chk("rv_early", {31'd0, bus.redirect_valid}, 32'd0);
      end
      tick();
      for (int k = 0; k <= stall; k++) begin
        bus.redirect_ready = (k == stall);
        #1;
        chk("flush_lo", {31'd0, flush}, 32'd0);
        chk("rv_hold", {31'd0, bus.redirect_valid}, 32'd1);
        chk("rpc_hold", bus.redirect_pc, tgt);
        chk("busy_ready2", {31'd0, bus.commit_ready}, 32'd0);
        tick();
      end
      bus.redirect_ready = 1'b0;
      #1;
      chk("rv_drop", {31'd0, bus.redirect_valid}, 32'd0);
      chk("ready_back", {31'd0, bus.commit_ready}, 32'd1);
    end else begin
      chk("no_flush", {31'd0, flush}, 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    hw_int = '0; status_ie = 0; status_exl = 0; status_im = '0; status_im_sw = '0;
    cause_ip_sw = '0; counter_int = 0; cp0_epc = '0;
    bus.commit_valid = 0; bus.commit_pc = '0; bus.commit_isds = 0; bus.commit_exc = '0;
    bus.commit_badva = '0; bus.redirect_ready = 0;
    last_type = '0; last_pc = '0; last_isds = 0; last_badva = '0;
    tick();
    tick();
    #1;
    chk("rst_ready", {31'd0, bus.commit_ready}, 32'd0);
    chk("rst_cause", {31'd0, cause_exce}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_rv", {31'd0, bus.redirect_valid}, 32'd0);
    chk("rst_rpc", bus.redirect_pc, 32'd0);
    chk("rst_i2c", {26'd0, int_to_cp0}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {31'd0, bus.commit_ready}, 32'd1);
    tick();

    commit(32'h80000010, 1'b0, 4'd0, 32'd0, 0);
    commit(32'h80000100, 1'b1, 4'd6, 32'd0, 0);
    commit(32'h80000200, 1'b0, 4'd2, 32'h80000003, 0);
    commit(32'h80000204, 1'b0, 4'd3, 32'h80000003, 0);
    cp0_epc = 32'h80001234;
    commit(32'h80000300, 1'b0, 4'd8, 32'd0, 0);

    hw_int = 6'b000001; status_im = 6'b000001; status_ie = 1; status_exl = 0;
    for (int i = 0; i < SYNC_LAT; i++) idle_cycle();
    commit(32'h80000400, 1'b0, 4'd4, 32'd0, 0);
    chk("int_taken", {28'd0, exce_type}, 32'd1);
    status_exl = 1;
    commit(32'h80000404, 1'b0, 4'd4, 32'd0, 0);
    chk("exl_blocks_int", {28'd0, exce_type}, 32'd4);
    cp0_epc = 32'h80002000;
    commit(32'h80000408, 1'b0, 4'd8, 32'd0, 0);
    hw_int = '0; status_exl = 0; status_ie = 0;
    idle_cycle();

    commit(32'h80000500, 1'b0, 4'd5, 32'd0, 5);

    bus.commit_valid = 1; bus.commit_pc = 32'h80000600; bus.commit_exc = 4'd3;
    tick();
    bus.commit_valid = 0;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_flush", {31'd0, flush}, 32'd0);
    chk("mid_rst_cause", {31'd0, cause_exce}, 32'd0);
    chk("mid_rst_ready", {31'd0, bus.commit_ready}, 32'd0);
    chk("mid_rst_pc", exce_pc, 32'd0);
    chk("mid_rst_rv", {31'd0, bus.redirect_valid}, 32'd0);
    tick();
    rst = 1'b0;
    last_type = '0; last_pc = '0; last_isds = 0; last_badva = '0;
    #1;
    chk("rel_ready", {31'd0, bus.commit_ready}, 32'd1);
    tick();
    #1;
    chk("rel_flush", {31'd0, flush}, 32'd0);
    tick();

    for (int n = 0; n < 40; n++) begin
      logic [3:0] excs[10];
      excs = '{4'd0, 4'd0, 4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
      status_ie    = $urandom_range(0, 1);
      status_exl   = ($urandom_range(0, 3) == 0);
      status_im    = 6'($urandom);
      status_im_sw = 2'($urandom);
      cause_ip_sw  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd0;
      counter_int  = ($urandom_range(0, 5) == 0);
      hw_int       = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) idle_cycle();
      commit($urandom, 1'($urandom), excs[$urandom_range(0, 9)], $urandom,
             int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
